// File: rtl/alu_issue_arbiter_if.sv
// Request, response and ALU-side signals of the shared ALU issue arbiter.
// The arbiter connects through the slave modport; the requesters and the ALU
// model (or a testbench) connect through the master modport.
interface alu_issue_arbiter_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREQ = 2
);
  // Pipeline control
  logic                 i_stall;
  logic                 i_flush;
  // Request channel, one lane per requester, packed
  logic [NREQ-1:0]      i_req_valid;
  logic [NREQ-1:0]      o_req_ready;
  logic [10*NREQ-1:0]   i_req_funct;
  logic [XLEN*NREQ-1:0] i_req_src1;
  logic [XLEN*NREQ-1:0] i_req_src2;
  // Response channel, data is broadcast and valid is routed to the owner
  logic [NREQ-1:0]      o_rsp_valid;
  logic [NREQ-1:0]      i_rsp_ready;
  logic [XLEN-1:0]      o_rsp_data;
  // ALU side
  logic                 o_alu_en;
  logic [9:0]           o_alu_funct;
  logic [XLEN-1:0]      o_alu_src1;
  logic [XLEN-1:0]      o_alu_src2;
  logic                 o_alu_stall;
  logic [XLEN-1:0]      i_alu_res;
  // Status
  logic                 o_busy;

  modport master (
    output i_stall, i_flush,
    output i_req_valid, i_req_funct, i_req_src1, i_req_src2,
    input  o_req_ready,
    input  o_rsp_valid, o_rsp_data,
    output i_rsp_ready,
    input  o_alu_en, o_alu_funct, o_alu_src1, o_alu_src2, o_alu_stall,
    output i_alu_res,
    input  o_busy
  );

  modport slave (
    input  i_stall, i_flush,
    input  i_req_valid, i_req_funct, i_req_src1, i_req_src2,
    output o_req_ready,
    output o_rsp_valid, o_rsp_data,
    input  i_rsp_ready,
    output o_alu_en, o_alu_funct, o_alu_src1, o_alu_src2, o_alu_stall,
    input  i_alu_res,
    output o_busy
  );
endinterface

// File: rtl/alu_issue_arbiter.sv
// Round-robin issue arbiter sharing one registered integer ALU between NREQ
// requesters. At most one operation is in flight; its result is routed back to
// the owning requester, and a new operation may issue in the same cycle the
// previous response is accepted, giving one operation per cycle.
module alu_issue_arbiter #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREQ = 2
) (
  input logic               clk,
  input logic               rstn,
  alu_issue_arbiter_if.slave bus
);

  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [0:0] {StIdle, StPend} state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;

  logic            rsp_fire;
  logic            can_issue;
  logic [NREQ-1:0] rsp_ready_sh;
  logic [NREQ-1:0] owner_oh;

  logic            gnt_valid;
  logic [IDW-1:0]  gnt_idx;
  logic [IDW-1:0]  gnt_next;
  logic [NREQ-1:0] gnt_oh;
  logic [9:0]      gnt_funct;
  logic [XLEN-1:0] gnt_src1;
  logic [XLEN-1:0] gnt_src2;

  // Shifts rather than variable bit-selects keep the owner lookup width-clean
  // for any NREQ, including non-powers of two.
  assign rsp_ready_sh = bus.i_rsp_ready >> owner_q;
  assign owner_oh     = NREQ'(1) << owner_q;

  // Only the owner's ready counts; a flush kills the response outright.
  assign rsp_fire  = (state_q == StPend) && rsp_ready_sh[0] && !bus.i_flush;
  assign can_issue = !bus.i_stall && !bus.i_flush && ((state_q == StIdle) || rsp_fire);

  assign gnt_next = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);

  // Round-robin selection: first valid requester at or after rr_ptr.
  always_comb begin : p_select
    int unsigned          k;
    logic [NREQ-1:0]      valid_sh;
    logic [10*NREQ-1:0]   funct_sh;
    logic [XLEN*NREQ-1:0] src1_sh;
    logic [XLEN*NREQ-1:0] src2_sh;
    k         = 0;
    valid_sh  = '0;
    funct_sh  = '0;
    src1_sh   = '0;
    src2_sh   = '0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    gnt_oh    = '0;
    gnt_funct = '0;
    gnt_src1  = '0;
    gnt_src2  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      k        = (32'(rr_ptr_q) + i) % NREQ;
      valid_sh = bus.i_req_valid >> k;
      if (can_issue && !gnt_valid && valid_sh[0]) begin
        funct_sh  = bus.i_req_funct >> (10 * k);
        src1_sh   = bus.i_req_src1 >> (XLEN * k);
        src2_sh   = bus.i_req_src2 >> (XLEN * k);
        gnt_valid = 1'b1;
        gnt_idx   = IDW'(k);
        gnt_oh    = NREQ'(1) << k;
        gnt_funct = funct_sh[9:0];
        gnt_src1  = src1_sh[XLEN-1:0];
        gnt_src2  = src2_sh[XLEN-1:0];
      end
    end
  end

  // State, owner and round-robin pointer registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StIdle;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Next state: flush wins, a grant (re)enters PEND, an accepted response
  // without a new grant returns to IDLE, otherwise hold.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    if (bus.i_flush) begin
      state_d = StIdle;
    end else if (gnt_valid) begin
      state_d  = StPend;
      owner_d  = gnt_idx;
      rr_ptr_d = gnt_next;
    end else if (rsp_fire) begin
      state_d = StIdle;
    end
  end

  // Outputs: grant and ALU drive from the selection, response from the owner.
  always_comb begin
    bus.o_req_ready = gnt_oh;
    bus.o_alu_en    = gnt_valid;
    bus.o_alu_funct = gnt_funct;
    bus.o_alu_src1  = gnt_src1;
    bus.o_alu_src2  = gnt_src2;
    bus.o_alu_stall = bus.i_stall;
    bus.o_rsp_valid = ((state_q == StPend) && !bus.i_flush) ? owner_oh : '0;
    bus.o_rsp_data  = bus.i_alu_res;
    bus.o_busy      = (state_q == StPend);
  end

`ifndef SYNTHESIS
  a_req_ready_onehot0: assert property (@(posedge clk) disable iff (!rstn)
    $onehot0(bus.o_req_ready));
  a_rsp_valid_onehot0: assert property (@(posedge clk) disable iff (!rstn)
    $onehot0(bus.o_rsp_valid));
  a_en_has_grant: assert property (@(posedge clk) disable iff (!rstn)
    bus.o_alu_en |-> (|bus.o_req_ready));
`endif

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Self-checking bench for alu_issue_arbiter with a registered ALU model and a
// response scoreboard. Inputs change on the falling edge; checks follow 1ns later.
module tb_alu_issue_arbiter;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREQ = 2;

  localparam logic [9:0] AluAdd  = 10'h000;
  localparam logic [9:0] AluSub  = 10'h100;
  localparam logic [9:0] AluSltu = 10'h003;
  localparam logic [9:0] AluXor  = 10'h004;

  typedef struct {
    int          id;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic rstn;
  logic [31:0] alu_res = '0;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  alu_issue_arbiter_if #(.XLEN(XLEN), .NREQ(NREQ)) bus ();

  alu_issue_arbiter #(.XLEN(XLEN), .NREQ(NREQ)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [9:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    case (f)
      AluAdd:  return a + b;
      AluSub:  return a - b;
      AluSltu: return {31'b0, a < b};
      AluXor:  return a ^ b;
      default: return '0;
    endcase
  endfunction

  // Registered ALU: one-cycle latency, holds its result while not enabled.
  always @(posedge clk) begin
    if (bus.o_alu_en && !bus.o_alu_stall)
      alu_res <= alu_f(bus.o_alu_funct, bus.o_alu_src1, bus.o_alu_src2);
  end
  assign bus.i_alu_res = alu_res;

  // Scoreboard: pop the oldest expectation whenever a response is accepted.
  always @(negedge clk) begin
    #4;
    if (rstn === 1'b1 && (bus.o_rsp_valid & bus.i_rsp_ready) != '0) begin
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL rsp_unexpected: got valid=%b data=%h, required no response",
                 bus.o_rsp_valid, bus.o_rsp_data);
      end else begin
        mon_e = sb_q.pop_front();
        if (bus.o_rsp_valid !== NREQ'(1 << mon_e.id) || bus.o_rsp_data !== mon_e.data) begin
          n_err++;
          $display("FAIL rsp_data: got valid=%b data=%h, required valid=%b data=%h",
                   bus.o_rsp_valid, bus.o_rsp_data, NREQ'(1 << mon_e.id), mon_e.data);
        end
      end
    end
  end

  task automatic set_req(input logic k, input logic v, input logic [9:0] f,
                         input logic [31:0] a, input logic [31:0] b);
    bus.i_req_valid[k]          = v;
    bus.i_req_funct[10*k +: 10] = f;
    bus.i_req_src1[32*k +: 32]  = a;
    bus.i_req_src2[32*k +: 32]  = b;
  endtask

  task automatic test_reset();
    rstn            = 1'b0;
    bus.i_stall     = 1'b0;
    bus.i_flush     = 1'b0;
    bus.i_req_valid = '0;
    bus.i_req_funct = '0;
    bus.i_req_src1  = '0;
    bus.i_req_src2  = '0;
    bus.i_rsp_ready = '0;
    repeat (2) @(negedge clk);
    #1;
    n_vec++; if (bus.o_req_ready !== 2'b00) begin n_err++; $display("FAIL reset_ready: got %b required 00", bus.o_req_ready); end
    n_vec++; if (bus.o_rsp_valid !== 2'b00) begin n_err++; $display("FAIL reset_rsp_valid: got %b required 00", bus.o_rsp_valid); end
    n_vec++; if (bus.o_alu_en !== 1'b0) begin n_err++; $display("FAIL reset_alu_en: got %b required 0", bus.o_alu_en); end
    n_vec++; if (bus.o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b required 0", bus.o_busy); end
    n_vec++; if (bus.o_alu_funct !== 10'h0) begin n_err++; $display("FAIL reset_funct: got %h required 0", bus.o_alu_funct); end
    n_vec++; if (bus.o_alu_src1 !== 32'h0) begin n_err++; $display("FAIL reset_src1: got %h required 0", bus.o_alu_src1); end
    n_vec++; if (bus.o_alu_src2 !== 32'h0) begin n_err++; $display("FAIL reset_src2: got %h required 0", bus.o_alu_src2); end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_single_add();
    @(negedge clk);
    bus.i_rsp_ready = 2'b11;
    set_req(1'b0, 1'b1, AluAdd, 32'd5, 32'd7);
    #1;
    n_vec++; if (bus.o_req_ready !== 2'b01) begin n_err++; $display("FAIL add_ready: got %b required 01", bus.o_req_ready); end
    n_vec++; if (bus.o_alu_en !== 1'b1) begin n_err++; $display("FAIL add_en: got %b required 1", bus.o_alu_en); end
    n_vec++; if (bus.o_alu_funct !== AluAdd) begin n_err++; $display("FAIL add_funct: got %h required %h", bus.o_alu_funct, AluAdd); end
    n_vec++; if (bus.o_alu_src1 !== 32'd5) begin n_err++; $display("FAIL add_src1: got %0d required 5", bus.o_alu_src1); end
    n_vec++; if (bus.o_alu_src2 !== 32'd7) begin n_err++; $display("FAIL add_src2: got %0d required 7", bus.o_alu_src2); end
    sb_q.push_back('{id: 0, data: 32'd12});
    @(negedge clk);
    set_req(1'b0, 1'b0, '0, '0, '0);
    #1;
    n_vec++; if (bus.o_busy !== 1'b1) begin n_err++; $display("FAIL add_busy: got %b required 1", bus.o_busy); end
    n_vec++; if (bus.o_rsp_valid !== 2'b01) begin n_err++; $display("FAIL add_rsp_valid: got %b required 01", bus.o_rsp_valid); end
    n_vec++; if (bus.o_rsp_data !== 32'd12) begin n_err++; $display("FAIL add_rsp_data: got %0d required 12", bus.o_rsp_data); end
    @(negedge clk);
    #1;
    n_vec++; if (bus.o_busy !== 1'b0) begin n_err++; $display("FAIL add_idle: got busy %b required 0", bus.o_busy); end
    n_vec++; if (bus.o_rsp_valid !== 2'b00) begin n_err++; $display("FAIL add_rsp_clear: got %b required 00", bus.o_rsp_valid); end
  endtask

  task automatic test_reset_mid_pend();
    @(negedge clk);
    bus.i_rsp_ready = 2'b00;
    set_req(1'b0, 1'b1, AluAdd, 32'd4, 32'd4);
    #1;
    n_vec++; if (bus.o_req_ready !== 2'b01) begin n_err++; $display("FAIL rstpend_ready: got %b required 01", bus.o_req_ready); end
    @(negedge clk);
    set_req(1'b0, 1'b0, '0, '0, '0);
    #1;
    n_vec++; if (bus.o_busy !== 1'b1) begin n_err++; $display("FAIL rstpend_busy: got %b required 1", bus.o_busy); end
    #1;
    rstn = 1'b0;
    #1;
    n_vec++; if (bus.o_busy !== 1'b0) begin n_err++; $display("FAIL rstpend_async_busy: got %b required 0", bus.o_busy); end
    n_vec++; if (bus.o_rsp_valid !== 2'b00) begin n_err++; $display("FAIL rstpend_async_rsp: got %b required 00", bus.o_rsp_valid); end
    n_vec++; if (bus.o_req_ready !== 2'b00) begin n_err++; $display("FAIL rstpend_async_ready: got %b required 00", bus.o_req_ready); end
    n_vec++; if (bus.o_alu_en !== 1'b0) begin n_err++; $display("FAIL rstpend_async_en: got %b required 0", bus.o_alu_en); end
    @(negedge clk);
    rstn = 1'b1;
    set_req(1'b0, 1'b1, AluAdd, 32'd0, 32'd0);
    set_req(1'b1, 1'b1, AluAdd, 32'd0, 32'd0);
    #1;
    n_vec++; if (bus.o_req_ready !== 2'b01) begin n_err++; $display("FAIL rstpend_rr_ptr: got %b required 01", bus.o_req_ready); end
    n_vec++; if (bus.o_busy !== 1'b0) begin n_err++; $display("FAIL rstpend_idle: got %b required 0", bus.o_busy); end
    set_req(1'b0, 1'b0, '0, '0, '0);
    set_req(1'b1, 1'b0, '0, '0, '0);
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_oh;
    @(negedge clk);
    bus.i_rsp_ready = 2'b11;
    set_req(1'b0, 1'b1, AluSub, 32'd9, 32'd4);
    set_req(1'b1, 1'b1, AluSltu, 32'd3, 32'd8);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 4) begin
        set_req(1'b0, 1'b0, '0, '0, '0);
        set_req(1'b1, 1'b0, '0, '0, '0);
      end
      #1;
      exp_oh = (c == 4) ? 2'b00 : ((c % 2 == 0) ? 2'b01 : 2'b10);
      n_vec++;
      if (bus.o_req_ready !== exp_oh) begin
        n_err++;
        $display("FAIL b2b_grant[%0d]: got %b required %b", c, bus.o_req_ready, exp_oh);
      end
      if (exp_oh == 2'b01) sb_q.push_back('{id: 0, data: 32'd5});
      if (exp_oh == 2'b10) sb_q.push_back('{id: 1, data: 32'd1});
      n_vec++;
      if (bus.o_busy !== (c > 0)) begin
        n_err++;
        $display("FAIL b2b_busy[%0d]: got %b required %b", c, bus.o_busy, c > 0);
      end
    end
  endtask

  task automatic test_rsp_backpressure();
    @(negedge clk);
    bus.i_rsp_ready = 2'b01;
    set_req(1'b1, 1'b1, AluXor, 32'hF0, 32'h0F);
    #1;
    n_vec++; if (bus.o_req_ready !== 2'b10) begin n_err++; $display("FAIL bp_ready: got %b required 10", bus.o_req_ready); end
    n_vec++; if (bus.o_alu_en !== 1'b1) begin n_err++; $display("FAIL bp_en: got %b required 1", bus.o_alu_en); end
    sb_q.push_back('{id: 1, data: 32'hFF});
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      set_req(1'b1, 1'b0, '0, '0, '0);
      set_req(1'b0, 1'b1, AluAdd, 32'd2, 32'd3);
      #1;
      n_vec++; if (bus.o_rsp_valid !== 2'b10) begin n_err++; $display("FAIL bp_hold_valid[%0d]: got %b required 10", c, bus.o_rsp_valid); end
      n_vec++; if (bus.o_rsp_data !== 32'hFF) begin n_err++; $display("FAIL bp_hold_data[%0d]: got %h required ff", c, bus.o_rsp_data); end
      n_vec++; if (bus.o_req_ready !== 2'b00) begin n_err++; $display("FAIL bp_no_grant[%0d]: got %b required 00", c, bus.o_req_ready); end
      n_vec++; if (bus.o_alu_en !== 1'b0) begin n_err++; $display("FAIL bp_no_en[%0d]: got %b required 0", c, bus.o_alu_en); end
    end
    @(negedge clk);
    bus.i_rsp_ready = 2'b11;
    #1;
    n_vec++; if (bus.o_rsp_valid !== 2'b10) begin n_err++; $display("FAIL bp_accept_valid: got %b required 10", bus.o_rsp_valid); end
    n_vec++; if (bus.o_req_ready !== 2'b01) begin n_err++; $display("FAIL bp_same_cycle_grant: got %b required 01", bus.o_req_ready); end
    sb_q.push_back('{id: 0, data: 32'd5});
    @(negedge clk);
    set_req(1'b0, 1'b0, '0, '0, '0);
    #1;
    n_vec++; if (bus.o_rsp_valid !== 2'b01) begin n_err++; $display("FAIL bp_next_rsp: got %b required 01", bus.o_rsp_valid); end
  endtask

  task automatic test_stall();
    @(negedge clk);
    bus.i_stall     = 1'b1;
    bus.i_rsp_ready = 2'b11;
    set_req(1'b0, 1'b1, AluAdd, 32'd10, 32'd20);
    for (int c = 0; c < 2; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      n_vec++; if (bus.o_req_ready !== 2'b00) begin n_err++; $display("FAIL stall_ready[%0d]: got %b required 00", c, bus.o_req_ready); end
      n_vec++; if (bus.o_alu_en !== 1'b0) begin n_err++; $display("FAIL stall_en[%0d]: got %b required 0", c, bus.o_alu_en); end
      n_vec++; if (bus.o_alu_stall !== 1'b1) begin n_err++; $display("FAIL stall_out[%0d]: got %b required 1", c, bus.o_alu_stall); end
    end
    @(negedge clk);
    bus.i_stall = 1'b0;
    #1;
    n_vec++; if (bus.o_req_ready !== 2'b01) begin n_err++; $display("FAIL stall_release_grant: got %b required 01", bus.o_req_ready); end
    n_vec++; if (bus.o_alu_stall !== 1'b0) begin n_err++; $display("FAIL stall_release_out: got %b required 0", bus.o_alu_stall); end
    sb_q.push_back('{id: 0, data: 32'd30});
    @(negedge clk);
    bus.i_stall = 1'b1;
    set_req(1'b0, 1'b0, '0, '0, '0);
    set_req(1'b1, 1'b1, AluXor, 32'd1, 32'd2);
    #1;
    n_vec++; if (bus.o_rsp_valid !== 2'b01) begin n_err++; $display("FAIL stall_pend_rsp: got %b required 01", bus.o_rsp_valid); end
    n_vec++; if (bus.o_req_ready !== 2'b00) begin n_err++; $display("FAIL stall_pend_ready: got %b required 00", bus.o_req_ready); end
    @(negedge clk);
    bus.i_stall = 1'b0;
    set_req(1'b1, 1'b0, '0, '0, '0);
    #1;
    n_vec++; if (bus.o_busy !== 1'b0) begin n_err++; $display("FAIL stall_to_idle: got busy %b required 0", bus.o_busy); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    bus.i_rsp_ready = 2'b11;
    set_req(1'b0, 1'b1, AluAdd, 32'd1, 32'd1);
    #1;
    n_vec++; if (bus.o_req_ready !== 2'b01) begin n_err++; $display("FAIL flush_issue: got %b required 01", bus.o_req_ready); end
    @(negedge clk);
    bus.i_flush = 1'b1;
    bus.i_stall = 1'b1;
    set_req(1'b0, 1'b0, '0, '0, '0);
    set_req(1'b1, 1'b1, AluSub, 32'd20, 32'd3);
    #1;
    n_vec++; if (bus.o_rsp_valid !== 2'b00) begin n_err++; $display("FAIL flush_rsp: got %b required 00", bus.o_rsp_valid); end
    n_vec++; if (bus.o_req_ready !== 2'b00) begin n_err++; $display("FAIL flush_ready: got %b required 00", bus.o_req_ready); end
    n_vec++; if (bus.o_alu_en !== 1'b0) begin n_err++; $display("FAIL flush_en: got %b required 0", bus.o_alu_en); end
    @(negedge clk);
    bus.i_flush = 1'b0;
    bus.i_stall = 1'b0;
    set_req(1'b0, 1'b1, AluAdd, 32'd1, 32'd1);
    #1;
    n_vec++; if (bus.o_busy !== 1'b0) begin n_err++; $display("FAIL flush_idle: got busy %b required 0", bus.o_busy); end
    n_vec++; if (bus.o_req_ready !== 2'b10) begin n_err++; $display("FAIL flush_rr_ptr: got %b required 10", bus.o_req_ready); end
    sb_q.push_back('{id: 1, data: 32'd17});
    @(negedge clk);
    set_req(1'b0, 1'b0, '0, '0, '0);
    set_req(1'b1, 1'b0, '0, '0, '0);
    #1;
    n_vec++; if (bus.o_rsp_valid !== 2'b10) begin n_err++; $display("FAIL flush_after_rsp: got %b required 10", bus.o_rsp_valid); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_reset_mid_pend();
    test_back_to_back();
    test_rsp_backpressure();
    test_stall();
    test_flush();
    repeat (2) @(negedge clk);
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drained: got %0d outstanding responses, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
